// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - snake-game move tick, speed level and blink sequencer
//
// Purpose:
//   Generates a one-cycle move_tick enable on the system clock whose period
//   shrinks with the speed level, a free-running blink square wave, and a
//   small IDLE/RUN/PAUSED/OVER game FSM that gates the tick.
//
// Optional feature macro: GTS_TURBO_EN
//   When defined, the turbo input exists.
//   A high turbo in a reload cycle (start or wrap) halves the latched period.
//
// Ports:
//   clk100Mhz   in   system clock
//   resetn      in   asynchronous reset, active-low
//   start       in   pulse: new game (from IDLE or OVER)
//   pause_tgl   in   pulse: toggle RUN <-> PAUSED
//   food_eaten  in   pulse: raise speed level (RUN only, saturating)
//   collide     in   pulse: game over (RUN or PAUSED)
//   turbo       in   hold for double speed (GTS_TURBO_EN only)
//   move_tick   out  one-cycle movement enable
//   blink       out  square wave, toggles every BLINK_DIV cycles
//   level       out  current speed level
//   state       out  IDLE=0, RUN=1, PAUSED=2, OVER=3
//   running     out  high while state is RUN

module game_tick_scheduler #(
  parameter int unsigned BASE_DIV  = 20_000_000,
  parameter int unsigned STEP_DIV  = 2_000_000,
  parameter int unsigned MIN_DIV   = 5_000_000,
  parameter int unsigned MAX_LEVEL = 7,
  parameter int unsigned LEVEL_W   = 3,
  parameter int unsigned CNT_W     = 28,
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input  logic               clk100Mhz,
  input  logic               resetn,
  input  logic               start,
  input  logic               pause_tgl,
  input  logic               food_eaten,
  input  logic               collide,
`ifdef GTS_TURBO_EN
  input  logic               turbo,
`endif
  output logic               move_tick,
  output logic               blink,
  output logic [LEVEL_W-1:0] level,
  output logic [1:0]         state,
  output logic               running
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_OVER   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0]   BASE_C  = CNT_W'(BASE_DIV);
  localparam logic [CNT_W-1:0]   STEP_C  = CNT_W'(STEP_DIV);
  localparam logic [CNT_W-1:0]   MIN_C   = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0]   BLINK_C = CNT_W'(BLINK_DIV);
  localparam logic [LEVEL_W-1:0] MAX_LV  = LEVEL_W'(MAX_LEVEL);
  // Largest reduction that still leaves the period at or above the floor.
  localparam logic [CNT_W-1:0]   HEADROOM = BASE_C - MIN_C;

  state_e             state_q;
  logic [LEVEL_W-1:0] level_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   period_lat_q;
  logic               move_tick_q;
  logic               running_q;
  logic [CNT_W-1:0]   blink_cnt_q;
  logic               blink_q;

  logic [CNT_W-1:0]   step_prod;
  logic [CNT_W-1:0]   period_cur;
  logic [CNT_W-1:0]   reload_d;
  logic [CNT_W-1:0]   start_period_d;
  logic               wrap;

  // Compare against the headroom before subtracting so the period never
  // underflows at high levels.
  always_comb begin
    step_prod  = CNT_W'(level_q) * STEP_C;
    period_cur = (step_prod >= HEADROOM) ? MIN_C : (BASE_C - step_prod);
  end

`ifdef GTS_TURBO_EN
  assign reload_d       = turbo ? (period_cur >> 1) : period_cur;
  assign start_period_d = turbo ? (BASE_C >> 1) : BASE_C;
`else
  assign reload_d       = period_cur;
  assign start_period_d = BASE_C;
`endif

  assign wrap = (cnt_q == (period_lat_q - CNT_W'(1)));

  always_ff @(posedge clk100Mhz or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      level_q      <= '0;
      cnt_q        <= '0;
      period_lat_q <= BASE_C;
      move_tick_q  <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      move_tick_q <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_q      <= S_RUN;
            running_q    <= 1'b1;
            cnt_q        <= '0;
            level_q      <= '0;
            period_lat_q <= start_period_d;
          end
        end
        S_RUN: begin
          if (collide) begin
            // Tick suppressed and cnt held on the way out of RUN.
            state_q   <= S_OVER;
            running_q <= 1'b0;
          end else begin
            if (food_eaten && (level_q != MAX_LV)) begin
              level_q <= level_q + LEVEL_W'(1);
            end
            if (pause_tgl) begin
              state_q   <= S_PAUSED;
              running_q <= 1'b0;
            end else if (wrap) begin
              // Reload sees the level as it was before any food this cycle.
              move_tick_q  <= 1'b1;
              cnt_q        <= '0;
              period_lat_q <= reload_d;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_PAUSED: begin
          if (collide) begin
            state_q <= S_OVER;
          end else if (pause_tgl) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk100Mhz or negedge resetn) begin
    if (!resetn) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == (BLINK_C - CNT_W'(1))) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CNT_W'(1);
    end
  end

  assign move_tick = move_tick_q;
  assign blink     = blink_q;
  assign level     = level_q;
  assign state     = state_q;
  assign running   = running_q;

endmodule
